// File: rtl/kgp_isa_pkg.sv
// ISA constants and the decoded control bundle shared by the decode stage and its decoder.
package kgp_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_BR    = 6'b001010;
  localparam logic [5:0] OP_JAL   = 6'b001011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [1:0] RD_RS = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;

  typedef struct packed {
    logic [1:0] regDst;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic [3:0] aluOp;
    logic       illegal;
    logic       isHalt;
  } ctrl_t;

  // I-type ALU opcodes occupy 000001..000111; 000000 is R-type.
  function automatic logic isItype(input logic [5:0] op);
    return (op[5:3] == 3'b000) && (op[2:0] != 3'b000);
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational opcode decoder: instruction word -> control bundle.
// Zero latency, no handshake; undefined opcodes decode as a flagged NOP.
module instr_decoder
  import kgp_isa_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [5:0] op;
  logic       unusedBits;

  assign op         = instr[31:26];
  assign unusedBits = ^instr[25:4];

  always_comb begin
    ctrl = '0;
    case (op)
      OP_RTYPE: begin
        ctrl.regDst   = RD_RS;
        ctrl.regWrite = 1'b1;
        ctrl.aluOp    = instr[3:0];
      end
      OP_LW: begin
        ctrl.regDst   = RD_RT;
        ctrl.regWrite = 1'b1;
        ctrl.memRead  = 1'b1;
        ctrl.aluOp    = ALU_ADD;
      end
      OP_SW: begin
        ctrl.memWrite = 1'b1;
        ctrl.aluOp    = ALU_ADD;
      end
      OP_BR: begin
        ctrl.branch = 1'b1;
        ctrl.aluOp  = ALU_SUB;
      end
      OP_JAL: begin
        ctrl.regDst   = RD_RA;
        ctrl.regWrite = 1'b1;
        ctrl.branch   = 1'b1;
      end
      OP_HALT: begin
        ctrl.isHalt = 1'b1;
      end
      default: begin
        if (isItype(op)) begin
          ctrl.regDst   = RD_RS;
          ctrl.regWrite = 1'b1;
          ctrl.aluOp    = {1'b1, op[2:0]};
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// IF/ID register + decode, 1-cycle latency, one entry; stalls fetch when full and not draining,
// inserts a 1-cycle load-use bubble, and blocks fetch permanently once a halt is handed off.
module instr_decode_stage
  import kgp_isa_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int REG_AW         = 5,
  parameter int PC_W           = 32,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [DATA_W-1:0] if_instr,
  input  logic [PC_W-1:0]   if_pc,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [REG_AW-1:0] rs,
  output logic [REG_AW-1:0] rt,
  output logic [1:0]        RegDst,
  output logic              RegWrite,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              Branch,
  output logic [3:0]        ALUOp,
  output logic [DATA_W-1:0] imm_ext,
  output logic [PC_W-1:0]   id_pc,
  output logic              illegal,
  output logic              halted
);

  logic [DATA_W-1:0] instrQ;
  logic [PC_W-1:0]   pcQ;
  logic              validQ;
  logic              luPending;
  logic [REG_AW-1:0] luDest;
  logic              haltedQ;

  logic              bubble;
  logic              idValid;
  logic              accept;
  logic              handoff;
  logic [REG_AW-1:0] rsW;
  logic [REG_AW-1:0] rtW;
  ctrl_t             dec;

  instr_decoder u_dec (
    .instr (instrQ[31:0]),
    .ctrl  (dec)
  );

  assign rsW = instrQ[21 +: REG_AW];
  assign rtW = instrQ[16 +: REG_AW];

  assign bubble  = (LOAD_USE_STALL != 0) && luPending && validQ &&
                   ((rsW == luDest) || (rtW == luDest));
  assign idValid = validQ && !bubble;
  assign handoff = idValid && id_ready;
  assign accept  = if_valid && if_ready;

  assign if_ready = !haltedQ && (!validQ || (id_ready && !bubble));

  always_ff @(posedge clk) begin
    if (rst) begin
      validQ    <= 1'b0;
      instrQ    <= '0;
      pcQ       <= '0;
      luPending <= 1'b0;
      luDest    <= '0;
      haltedQ   <= 1'b0;
    end else begin
      // Flush drops both the held word and any word arriving this cycle.
      if (flush) begin
        validQ <= 1'b0;
      end else if (accept) begin
        validQ <= 1'b1;
        instrQ <= if_instr;
        pcQ    <= if_pc;
      end else if (handoff) begin
        validQ <= 1'b0;
      end

      luPending <= handoff && dec.memRead && !flush;
      if (handoff && dec.memRead) begin
        luDest <= rtW;
      end

      if (handoff && dec.isHalt) begin
        haltedQ <= 1'b1;
      end
    end
  end

  // Controls are qualified by id_valid so an empty slot or bubble never enables a write.
  assign id_valid = idValid;
  assign rs       = rsW;
  assign rt       = rtW;
  assign RegDst   = idValid ? dec.regDst : RD_RS;
  assign RegWrite = idValid && dec.regWrite;
  assign MemRead  = idValid && dec.memRead;
  assign MemWrite = idValid && dec.memWrite;
  assign Branch   = idValid && dec.branch;
  assign ALUOp    = idValid ? dec.aluOp : ALU_ADD;
  assign imm_ext  = {{(DATA_W-16){instrQ[15]}}, instrQ[15:0]};
  assign id_pc    = pcQ;
  assign illegal  = validQ && dec.illegal;
  assign halted   = haltedQ;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed-vector bench for instr_decode_stage; inputs change and outputs are sampled on negedge.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [1:0]  RegDst;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        Branch;
  logic [3:0]  ALUOp;
  logic [31:0] imm_ext;
  logic [31:0] id_pc;
  logic        illegal;
  logic        halted;

  int nVec = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  instr_decode_stage #(
    .DATA_W(32), .REG_AW(5), .PC_W(32), .LOAD_USE_STALL(1)
  ) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .rs(rs), .rt(rt), .RegDst(RegDst), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp),
    .imm_ext(imm_ext), .id_pc(id_pc), .illegal(illegal), .halted(halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0; id_ready = 1'b0;
    @(negedge clk);
    tick();
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_if_ready", 32'(if_ready), 32'd1);
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_rs",       32'(rs),       32'd0);
    check("rst_halted",   32'(halted),   32'd0);
    check("rst_id_pc",    id_pc,         32'd0);
    rst = 1'b0;

    // R-type accept with downstream stalled
    if_valid = 1'b1; if_instr = 32'h00220001; if_pc = 32'h100;
    tick();
    check("r_id_valid", 32'(id_valid), 32'd1);
    check("r_rs",       32'(rs),       32'd1);
    check("r_rt",       32'(rt),       32'd2);
    check("r_regdst",   32'(RegDst),   32'd0);
    check("r_regwrite", 32'(RegWrite), 32'd1);
    check("r_aluop",    32'(ALUOp),    32'd1);
    check("r_id_pc",    id_pc,         32'h100);

    // Hold for 3 clocks while the next word waits
    if_instr = 32'h00430002; if_pc = 32'h104;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_id_valid", 32'(id_valid), 32'd1);
      check("hold_rs",       32'(rs),       32'd1);
      check("hold_aluop",    32'(ALUOp),    32'd1);
      check("hold_id_pc",    id_pc,         32'h100);
      check("hold_if_ready", 32'(if_ready), 32'd0);
    end
    id_ready = 1'b1;
    tick();
    check("rel_w1_valid", 32'(id_valid), 32'd1);
    check("rel_w1_rs",    32'(rs),       32'd2);
    check("rel_w1_aluop", 32'(ALUOp),    32'd2);
    check("rel_w1_pc",    id_pc,         32'h104);
    if_valid = 1'b0;
    tick();
    check("rel_drained", 32'(id_valid), 32'd0);

    // Load-use: lw r3 then R-type reading r3
    if_valid = 1'b1; if_instr = 32'h20230004; if_pc = 32'h200;
    tick();
    check("lw_valid",    32'(id_valid), 32'd1);
    check("lw_regdst",   32'(RegDst),   32'd1);
    check("lw_memread",  32'(MemRead),  32'd1);
    check("lw_regwrite", 32'(RegWrite), 32'd1);
    check("lw_aluop",    32'(ALUOp),    32'd0);
    check("lw_imm",      imm_ext,       32'd4);
    if_instr = 32'h00620001; if_pc = 32'h204;
    tick();
    if_valid = 1'b0;
    check("lu_bubble_valid",    32'(id_valid), 32'd0);
    check("lu_bubble_if_ready", 32'(if_ready), 32'd0);
    check("lu_bubble_regwrite", 32'(RegWrite), 32'd0);
    tick();
    check("lu_after_valid",   32'(id_valid), 32'd1);
    check("lu_after_rs",      32'(rs),       32'd3);
    check("lu_after_memread", 32'(MemRead),  32'd0);
    check("lu_after_pc",      id_pc,         32'h204);
    tick();
    check("lu_drained", 32'(id_valid), 32'd0);

    // Flush coincident with accept drops the word
    if_valid = 1'b1; if_instr = 32'h00A50003; if_pc = 32'h300; flush = 1'b1;
    tick();
    if_valid = 1'b0; flush = 1'b0;
    check("flush_acc_valid",    32'(id_valid), 32'd0);
    check("flush_acc_if_ready", 32'(if_ready), 32'd1);
    tick();
    check("flush_acc_valid2", 32'(id_valid), 32'd0);

    // Flush of a held instruction
    id_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h00220001; if_pc = 32'h310;
    tick();
    if_valid = 1'b0;
    check("flush_held_pre", 32'(id_valid), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_held_post", 32'(id_valid), 32'd0);

    // Illegal opcode
    if_valid = 1'b1; if_instr = 32'h40000000; if_pc = 32'h400;
    tick();
    if_valid = 1'b0;
    check("ill_valid",    32'(id_valid), 32'd1);
    check("ill_illegal",  32'(illegal),  32'd1);
    check("ill_regwrite", 32'(RegWrite), 32'd0);
    check("ill_branch",   32'(Branch),   32'd0);
    id_ready = 1'b1;
    tick();
    check("ill_gone", 32'(illegal), 32'd0);

    // Streamed: sw, branch, jal, I-type with negative immediate
    if_valid = 1'b1; if_instr = 32'h24230008;
    tick();
    check("sw_memwrite", 32'(MemWrite), 32'd1);
    check("sw_regwrite", 32'(RegWrite), 32'd0);
    check("sw_aluop",    32'(ALUOp),    32'd0);
    check("sw_imm",      imm_ext,       32'd8);
    if_instr = 32'h28220010;
    tick();
    check("br_branch", 32'(Branch),   32'd1);
    check("br_aluop",  32'(ALUOp),    32'd1);
    check("br_regwr",  32'(RegWrite), 32'd0);
    if_instr = 32'h2C000000;
    tick();
    check("jal_regdst", 32'(RegDst),   32'd2);
    check("jal_regwr",  32'(RegWrite), 32'd1);
    check("jal_branch", 32'(Branch),   32'd1);
    if_instr = 32'h0C22FFFF;
    tick();
    check("it_aluop",  32'(ALUOp),    32'hB);
    check("it_regwr",  32'(RegWrite), 32'd1);
    check("it_regdst", 32'(RegDst),   32'd0);
    check("it_imm",    imm_ext,       32'hFFFFFFFF);

    // Halt
    if_instr = 32'hFC000000;
    tick();
    if_valid = 1'b0;
    check("halt_held_valid",  32'(id_valid), 32'd1);
    check("halt_held_regwr",  32'(RegWrite), 32'd0);
    check("halt_held_halted", 32'(halted),   32'd0);
    tick();
    check("halt_halted",   32'(halted),   32'd1);
    check("halt_if_ready", 32'(if_ready), 32'd0);
    if_valid = 1'b1; if_instr = 32'h00220001;
    tick();
    tick();
    check("halt_no_accept", 32'(id_valid), 32'd0);
    check("halt_if_ready2", 32'(if_ready), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("halt_survives_flush", 32'(halted), 32'd1);
    if_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_halted",   32'(halted),   32'd0);
    check("rst2_if_ready", 32'(if_ready), 32'd1);
    check("rst2_id_valid", 32'(id_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
